// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer: issues in-order fetch requests and queues {pc, instr} pairs for the IF/ID register.
// Optional performance counters are enabled with `define IPB_PERF_EN.
module instr_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
`ifdef IPB_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_drop_cnt,
`endif
    output logic [63:0] out_snxt_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [63:0]   fetch_pc_reg;
    logic [63:0]   pc_tag_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] occ_reg;
    logic [CW-1:0] inflight_reg;
    logic [CW-1:0] drop_cnt_reg;
    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [CW:0]      credit_sum;
    logic             req_hs;
    logic             resp_drop;
    logic             push;
    logic             pop;
    logic [CW-1:0]    inflight_next;
    logic [63:0]      redirect_aligned;
    logic [DEPTH-1:0] wr_en;

    // Entries plus outstanding requests never exceed DEPTH, so a response always has a free slot.
    assign credit_sum       = {1'b0, occ_reg} + {1'b0, inflight_reg};
    assign mem_req_valid    = !rst && !redirect_en && (credit_sum < DEPTH_W);
    assign mem_req_addr     = fetch_pc_reg;
    assign req_hs           = mem_req_valid && mem_req_ready;
    assign resp_drop        = mem_resp_valid && ((drop_cnt_reg != '0) || redirect_en);
    assign push             = mem_resp_valid && !resp_drop;
    assign pop              = out_valid && out_ready && !redirect_en;
    assign inflight_next    = inflight_reg + CW'(req_hs) - CW'(mem_resp_valid);
    assign redirect_aligned = redirect_pc & ~64'd3;

    assign out_valid   = (occ_reg != '0);
    assign out_pc      = pc_mem[rd_ptr_reg];
    assign out_instr   = instr_mem[rd_ptr_reg];
    assign out_snxt_pc = out_pc + 64'd4;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            pc_tag_reg   <= RESET_PC;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            occ_reg      <= '0;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
            if (redirect_en) begin
                // Every request still outstanding after this edge belongs to the old stream.
                fetch_pc_reg <= redirect_aligned;
                pc_tag_reg   <= redirect_aligned;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                occ_reg      <= '0;
                drop_cnt_reg <= inflight_next;
            end else begin
                if (req_hs) fetch_pc_reg <= fetch_pc_reg + 64'd4;
                if (push) begin
                    pc_tag_reg <= pc_tag_reg + 64'd4;
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
                if (push && !pop)
                    occ_reg <= occ_reg + CW'(1);
                else if (!push && pop)
                    occ_reg <= occ_reg - CW'(1);
                if (mem_resp_valid && (drop_cnt_reg != '0))
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    pc_mem[i]    <= pc_tag_reg;
                    instr_mem[i] <= mem_resp_instr;
                end
            end
        end
    end

`ifdef IPB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_en)             perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (resp_drop)               perf_drop_cnt  <= perf_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Randomized bench for instr_prefetch_buf: an in-order memory model and a queue-level
// model of the expected instruction stream check every cycle.
module tb_instr_prefetch_buf;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [63:0] out_snxt_pc;
`ifdef IPB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    instr_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_instr (mem_resp_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
`ifdef IPB_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
`endif
        .out_snxt_pc    (out_snxt_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        memq[$];     // requests accepted by memory, oldest first
    logic [63:0] fifo_q[$];   // pcs the consumer should see next
    logic [63:0] fetch_pc_m;
    int          stall_m, flush_m, drop_m;
    int          n_checks, n_errors, cyc;

    int          redir_pct, ready_pct, oready_pct, resp_pct, lat_max;
    bit          force_redir;
    logic [63:0] force_pc;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_knobs(input int rd, input int rr, input int orr, input int rs, input int lat);
        redir_pct  = rd;
        ready_pct  = rr;
        oready_pct = orr;
        resp_pct   = rs;
        lat_max    = lat;
    endtask

    // Called at a negedge; drives one cycle, checks outputs, advances the model, returns at next negedge.
    task automatic step();
        bit   resp, hs, pop, exp_rv;
        req_t e;
        redirect_en    = force_redir || ($urandom_range(0, 99) < redir_pct);
        redirect_pc    = force_redir ? force_pc
                                     : {28'h0, 4'($urandom), 32'h8000_0000 + ($urandom & 32'h0000_ffff)};
        mem_req_ready  = $urandom_range(0, 99) < ready_pct;
        out_ready      = $urandom_range(0, 99) < oready_pct;
        resp           = (memq.size() != 0) && (memq[0].due <= cyc) && ($urandom_range(0, 99) < resp_pct);
        mem_resp_valid = resp;
        mem_resp_instr = resp ? instr_of(memq[0].addr) : $urandom;
        #1;
        exp_rv = !redirect_en && (fifo_q.size() + memq.size() < DEPTH);
        check("req_valid", 64'(mem_req_valid), 64'(exp_rv));
        if (exp_rv) check("req_addr", mem_req_addr, fetch_pc_m);
        check("out_valid", 64'(out_valid), 64'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            check("out_pc", out_pc, fifo_q[0]);
            check("out_instr", 64'(out_instr), 64'(instr_of(fifo_q[0])));
            check("out_snxt_pc", out_snxt_pc, fifo_q[0] + 64'd4);
        end
`ifdef IPB_PERF_EN
        check("perf_stall", 64'(perf_stall_cnt), 64'(stall_m));
        check("perf_flush", 64'(perf_flush_cnt), 64'(flush_m));
        check("perf_drop", 64'(perf_drop_cnt), 64'(drop_m));
`endif
        hs  = exp_rv && mem_req_ready;
        pop = (fifo_q.size() != 0) && out_ready && !redirect_en;
        if ((fifo_q.size() != 0) && !out_ready) stall_m++;
        if (pop) begin
            $display("txn cycle=%0d pc=%h instr=%h", cyc, fifo_q[0], instr_of(fifo_q[0]));
            void'(fifo_q.pop_front());
        end
        if (resp) begin
            e = memq.pop_front();
            if (e.stale || redirect_en) drop_m++;
            else fifo_q.push_back(e.addr);
        end
        if (redirect_en) begin
            flush_m++;
            fifo_q.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            fetch_pc_m = {redirect_pc[63:2], 2'b00};
        end
        if (hs) begin
            memq.push_back('{addr: fetch_pc_m, stale: 1'b0, due: cyc + int'($urandom_range(1, lat_max))});
            fetch_pc_m += 64'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        fifo_q.delete();
        memq.delete();
        fetch_pc_m = RESET_PC;
        stall_m    = 0;
        flush_m    = 0;
        drop_m     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_out_pc"}, out_pc, 64'd0);
        check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
`ifdef IPB_PERF_EN
        check({tag, "_perf_stall"}, 64'(perf_stall_cnt), 64'd0);
        check({tag, "_perf_drop"}, 64'(perf_drop_cnt), 64'd0);
`endif
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        force_redir    = 1'b0;
        force_pc       = '0;
        rst            = 1'b1;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_instr = '0;
        out_ready      = 1'b1;
        model_reset();

        // Power-on reset held for three cycles, released at a negedge.
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Steady streaming, single-cycle memory.
        set_knobs(0, 100, 100, 100, 1);
        run(20);

        // Consumer stalled: credits cap the stream at DEPTH, then it resumes.
        set_knobs(0, 100, 0, 100, 1);
        run(15);
        set_knobs(0, 100, 100, 100, 1);
        run(10);

        // Mixed random traffic with redirects.
        set_knobs(5, 70, 70, 70, 3);
        run(1500);

        // Misaligned redirect target, then fill the buffer.
        force_redir = 1'b1;
        force_pc    = 64'h8000_0006;
        set_knobs(0, 100, 0, 100, 1);
        run(1);
        force_redir = 1'b0;
        run(10);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);

        // Asynchronous reset mid-cycle: outputs must drop without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        model_reset();
        mem_resp_valid = 1'b0;
        redirect_en    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Memory not ready: request must hold at the reset address.
        set_knobs(0, 0, 100, 100, 1);
        run(5);
        set_knobs(0, 100, 100, 100, 1);
        run(10);

        // Redirect-heavy random traffic.
        set_knobs(15, 60, 60, 60, 4);
        run(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buf.md
Name: instr_prefetch_buf

Overview:
- Fetch-side stage upstream of the IF/ID pipeline register.
- Issues in-order instruction-memory requests on a valid/ready channel and buffers returned {pc, instr} pairs in a DEPTH-entry FIFO.
- Presents the FIFO head to the fetch register with a valid/ready handshake.
- On a jump/branch redirect, flushes the FIFO, drops stale in-flight responses and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2; also the cap on entries plus in-flight requests
RESET_PC, 64'h80000000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
redirect_en  in  1  jump/branch redirect strobe
redirect_pc  in  64  redirect target
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  64  fetch address, word aligned
mem_resp_valid  in  1  response valid; in order; always accepted
mem_resp_instr  in  32  returned instruction
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer takes head; low while stalled (load-hazard stop)
out_pc  out  64  head pc
out_instr  out  32  head instruction
out_snxt_pc  out  64  out_pc + 4

Behaviour:
- Reset (async assert):
  - fetch_pc = RESET_PC.
  - FIFO empty; rd/wr pointers, occupancy, inflight and drop_cnt all 0; storage 0.
  - out_valid = 0, mem_req_valid = 0, out_pc = 0, out_instr = 0.
- Counter widths: inflight, drop_cnt and occupancy are $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Request issue:
  - mem_req_valid = !rst && !redirect_en && (occupancy + inflight < DEPTH).
  - mem_req_addr = fetch_pc, held stable while valid && !ready.
  - Handshake (valid && ready): fetch_pc += 4, inflight += 1.
- First request is valid in the first cycle after reset deasserts.
- Response handling:
  - mem_resp_valid decrements inflight.
  - If drop_cnt != 0, or redirect_en is high the same cycle: discard the response; drop_cnt -= 1 when nonzero.
  - Otherwise write {pc_tag, instr} at wr_ptr. pc_tag is a separate counter: set to RESET_PC on reset, set to the aligned redirect target on redirect, advanced by 4 per accepted response.
- Output:
  - out_valid = occupancy != 0; head fields are read combinationally from rd_ptr.
  - Pop on out_valid && out_ready.
  - Minimum latency is 1 cycle from a response edge to out_valid.
- Simultaneous push and pop: occupancy unchanged. A push at full cannot occur, because the credit rule forbids it.
- Redirect (redirect_en high at an edge):
  - fetch_pc and pc_tag <= {redirect_pc[63:2], 2'b00}; low bits are silently cleared.
  - FIFO cleared (pointers and occupancy 0); a same-cycle pop or push is ignored.
  - drop_cnt <= inflight_next, i.e. all requests outstanding after this edge, counting a same-cycle handshake (none is possible, since valid is forced low) and excluding a same-cycle response.
  - out_valid = 0 the next cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed from the current inflight each time.
- Reset mid-operation: all in-flight requests are forgotten. Memory must not return responses for pre-reset requests.

Optional Feature:
IPB_PERF_EN
- Defined: adds three outputs, all async-reset to 0 and wrapping at 2^32:
  - perf_stall_cnt[31:0]: cycles with out_valid && !out_ready.
  - perf_flush_cnt[31:0]: redirect events.
  - perf_drop_cnt[31:0]: discarded responses.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. Reset low after 3 cycles; mem_req_ready=1; response 1 cycle after each request with instr = addr[31:0]; out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008…; out_instr = out_pc[31:0]; out_snxt_pc = out_pc+4.
2. out_ready=0, DEPTH=4 -> exactly 4 requests (0x80000000–0x8000000C), then mem_req_valid=0 and out_valid=1 held. Raise out_ready -> requests resume at 0x80000010 after the first pop.
3. Two requests in flight, redirect_en with redirect_pc=0x80001000 -> both late responses discarded (perf_drop_cnt=2 if enabled); next out_pc=0x80001000.
4. Redirect coinciding with a response edge -> that response is discarded; drop_cnt covers only the remaining in-flight requests; FIFO empty next cycle.
5. mem_req_ready=0 for 5 cycles -> mem_req_valid stays 1 with mem_req_addr constant at 0x80000000; no inflight change.
6. Redirect to 0x80000006 -> next mem_req_addr=0x80000004 and the first out_pc=0x80000004. Assert rst asynchronously while out_valid=1 -> out_valid and mem_req_valid drop immediately, without waiting for a clock edge.
